// File: rtl/centscale_scheduler_pkg.sv
// rtl/centscale_scheduler_pkg.sv - shared widths, constants and FSM encoding for the centerScale scheduler
package centscale_scheduler_pkg;

    localparam int NCH_DEF = 4;
    localparam int CHW_DEF = 2;
    localparam int ADC_W   = 21;
    localparam int FP_W    = 32;

    // Reset value of every std entry, so an unconfigured channel scales by 1.0
    localparam logic [FP_W-1:0] FP_ONE = 32'h3F80_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/centscale_scheduler_tag_fifo.sv
// rtl/centscale_scheduler_tag_fifo.sv - in-order channel tag FIFO for samples in flight
module centscale_scheduler_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: entries are only read once counted as valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/centscale_scheduler.sv
// rtl/centscale_scheduler.sv - time-shares one centerScale instance among NCH ADC channels
module centscale_scheduler
    import centscale_scheduler_pkg::*;
#(
    parameter int NCH          = NCH_DEF,
    parameter int CHW          = CHW_DEF,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                 clk,
    input  logic                 GlobalReset,
    input  logic                 en,
    input  logic [NCH-1:0]       req_valid,
    input  logic [NCH*ADC_W-1:0] req_data,
    output logic [NCH-1:0]       req_ack,
    input  logic                 cfg_we,
    input  logic [CHW-1:0]       cfg_ch,
    input  logic                 cfg_sel,
    input  logic [FP_W-1:0]      cfg_data,
    output logic [ADC_W-1:0]     cs_x_adc,
    output logic [FP_W-1:0]      cs_mean,
    output logic [FP_W-1:0]      cs_std,
    output logic                 cs_srdyi,
    input  logic [FP_W-1:0]      cs_result,
    input  logic                 cs_srdyo,
    output logic [FP_W-1:0]      z_o,
    output logic [CHW-1:0]       z_ch_o,
    output logic                 z_valid_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int CNTW = $clog2(MAX_INFLIGHT) + 1;

    sched_state_t    state;
    logic [CHW-1:0]  rr_ptr;
    logic [FP_W-1:0] mean_tab [NCH];
    logic [FP_W-1:0] std_tab  [NCH];

    logic            grant_found;
    logic [CHW-1:0]  grant_ch;
    logic            issue;
    logic            fifo_pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic [CHW-1:0]  fifo_head;
    logic [CNTW-1:0] fifo_count;
    logic            inflight_nz;

    assign inflight_nz = (fifo_count != '0);

    // Round-robin search: first requester at or after the pointer, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!grant_found && req_valid[(int'(rr_ptr) + k) % NCH]) begin
                grant_found = 1'b1;
                grant_ch    = CHW'((int'(rr_ptr) + k) % NCH);
            end
        end
    end

    // A slot freed by a same-cycle return is not reusable until the next cycle
    assign issue    = (state == ST_RUN) && en && grant_found && !fifo_full;
    assign req_ack  = issue ? ({{(NCH-1){1'b0}}, 1'b1} << grant_ch) : '0;
    assign fifo_pop = cs_srdyo && !fifo_empty;

    centscale_scheduler_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (CHW)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (GlobalReset),
        .push      (issue),
        .push_data (grant_ch),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Sequencer: IDLE until enabled, DRAIN lets in-flight samples come home
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state  <= ST_RUN;
                        busy_o <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        if (inflight_nz) begin
                            state <= ST_DRAIN;
                        end else begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (en) begin
                        state <= ST_RUN;
                    end else if (!inflight_nz) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel mean/std table; a grant this cycle still sees the old entry
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            for (int i = 0; i < NCH; i++) begin
                mean_tab[i] <= '0;
                std_tab[i]  <= FP_ONE;
            end
        end else if (cfg_we) begin
            if (cfg_sel) begin
                std_tab[cfg_ch] <= cfg_data;
            end else begin
                mean_tab[cfg_ch] <= cfg_data;
            end
        end
    end

    // Round-robin pointer moves past the granted channel
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant_ch == CHW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
        end
    end

    // Operand registers hold between issues; strobe is a single-cycle pulse
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            cs_x_adc <= '0;
            cs_mean  <= '0;
            cs_std   <= '0;
            cs_srdyi <= 1'b0;
        end else begin
            cs_srdyi <= issue;
            if (issue) begin
                cs_x_adc <= req_data[ADC_W*grant_ch +: ADC_W];
                cs_mean  <= mean_tab[grant_ch];
                cs_std   <= std_tab[grant_ch];
            end
        end
    end

    // Result tagging; a return with nothing in flight is flagged and dropped
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            z_o       <= '0;
            z_ch_o    <= '0;
            z_valid_o <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            z_valid_o <= fifo_pop;
            if (fifo_pop) begin
                z_o    <= cs_result;
                z_ch_o <= fifo_head;
            end
            if (cs_srdyo && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_centscale_scheduler.sv
// tb/tb_centscale_scheduler.sv - self-checking bench for centscale_scheduler
module tb_centscale_scheduler;

    localparam int NCH  = 4;
    localparam int MAXI = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

    logic        clk;
    logic        GlobalReset;
    logic        en;
    logic [3:0]  req_valid;
    logic [83:0] req_data;
    logic [3:0]  req_ack;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic        cfg_sel;
    logic [31:0] cfg_data;
    logic [20:0] cs_x_adc;
    logic [31:0] cs_mean;
    logic [31:0] cs_std;
    logic        cs_srdyi;
    logic [31:0] cs_result;
    logic        cs_srdyo;
    logic [31:0] z_o;
    logic [1:0]  z_ch_o;
    logic        z_valid_o;
    logic        busy_o;
    logic        err_o;

    centscale_scheduler dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .en          (en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .cs_x_adc    (cs_x_adc),
        .cs_mean     (cs_mean),
        .cs_std      (cs_std),
        .cs_srdyi    (cs_srdyi),
        .cs_result   (cs_result),
        .cs_srdyo    (cs_srdyo),
        .z_o         (z_o),
        .z_ch_o      (z_ch_o),
        .z_valid_o   (z_valid_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_state;
    int          m_ptr;
    int          m_q[$];
    logic [31:0] m_mean [NCH];
    logic [31:0] m_std  [NCH];
    logic [20:0] m_x;
    logic [31:0] m_cmean, m_cstd, m_z;
    logic        m_srdyi, m_zv, m_err;
    int          m_zch;

    // centerScale stand-in and observation logs
    int   cyc = 0;
    int   lat = 3;
    int   pend[$];
    logic cs_hold = 1'b0;
    int   rel_req = 0;
    int   spur_req = 0;
    int   grant_log[$];
    int   zch_log[$];
    int   ack_cnt = 0, srdyi_cnt = 0, zv_cnt = 0;
    int   rr_exp[5] = '{0, 1, 2, 3, 0};
    logic [3:0] last_ack;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_ptr   = 0;
        m_q.delete();
        for (int i = 0; i < NCH; i++) begin
            m_mean[i] = 32'h0;
            m_std[i]  = 32'h3F80_0000;
        end
        m_x = '0; m_cmean = '0; m_cstd = '0; m_z = '0;
        m_srdyi = 1'b0; m_zv = 1'b0; m_err = 1'b0; m_zch = 0;
    endtask

    // Mid-cycle: compare every output against the model, then advance the model
    task automatic half();
        int g;
        int had;
        logic [3:0] eack;
        @(negedge clk);
        if (!GlobalReset) model_reset();
        g = -1;
        if (GlobalReset && m_state == M_RUN && en && m_q.size() < MAXI) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        eack = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk("req_ack",   32'(req_ack),   32'(eack));
        chk("cs_x_adc",  32'(cs_x_adc),  32'(m_x));
        chk("cs_mean",   cs_mean,        m_cmean);
        chk("cs_std",    cs_std,         m_cstd);
        chk("cs_srdyi",  32'(cs_srdyi),  32'(m_srdyi));
        chk("z_o",       z_o,            m_z);
        chk("z_ch_o",    32'(z_ch_o),    32'(m_zch));
        chk("z_valid_o", 32'(z_valid_o), 32'(m_zv));
        chk("busy_o",    32'(busy_o),    32'(m_state != M_IDLE));
        chk("err_o",     32'(err_o),     32'(m_err));
        if (GlobalReset) begin
            if (req_ack != 0) begin
                ack_cnt++;
                for (int c = 0; c < NCH; c++) if (req_ack[c]) grant_log.push_back(c);
            end
            if (cs_srdyi) srdyi_cnt++;
            if (z_valid_o) begin
                zv_cnt++;
                zch_log.push_back(int'(z_ch_o));
            end
            had  = m_q.size();
            m_zv = cs_srdyo && (had > 0);
            if (m_zv) begin
                m_z   = cs_result;
                m_zch = m_q.pop_front();
            end
            if (cs_srdyo && had == 0) m_err = 1'b1;
            m_srdyi = (g >= 0);
            if (g >= 0) begin
                m_x     = req_data[g*21 +: 21];
                m_cmean = m_mean[g];
                m_cstd  = m_std[g];
                m_ptr   = (g + 1) % NCH;
                m_q.push_back(g);
            end
            if (cfg_we) begin
                if (cfg_sel) m_std[cfg_ch] = cfg_data;
                else         m_mean[cfg_ch] = cfg_data;
            end
            case (m_state)
                M_IDLE:  if (en) m_state = M_RUN;
                M_RUN:   if (!en) m_state = (had > 0) ? M_DRAIN : M_IDLE;
                default: if (en) m_state = M_RUN; else if (had == 0) m_state = M_IDLE;
            endcase
        end
    endtask

    // Just after the edge: centerScale stand-in accepts issues and returns results in order
    task automatic rise();
        @(posedge clk);
        #1;
        cyc++;
        if (cs_srdyi) pend.push_back(cyc + lat);
        cs_srdyo = 1'b0;
        if (spur_req > 0) begin
            spur_req--;
            cs_srdyo  = 1'b1;
            cs_result = $urandom;
        end else if (pend.size() > 0 && ((!cs_hold && pend[0] <= cyc) || (cs_hold && rel_req > 0))) begin
            if (cs_hold) rel_req--;
            void'(pend.pop_front());
            cs_srdyo  = 1'b1;
            cs_result = $urandom;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            half();
            rise();
        end
    endtask

    task automatic wait_ack(input string nm, input logic [3:0] exp);
        int i;
        i = 0;
        half();
        while (req_ack == 4'b0 && i < 30) begin
            rise();
            half();
            i++;
        end
        chk(nm, 32'(req_ack), 32'(exp));
        rise();
    endtask

    initial begin
        GlobalReset = 1'b0;
        en = 1'b0; req_valid = '0; req_data = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0;
        cs_result = '0; cs_srdyo = 1'b0;
        model_reset();

        // Reset state
        cycles(2);
        half();
        chk("rst_busy",   32'(busy_o),    32'h0);
        chk("rst_zvalid", 32'(z_valid_o), 32'h0);
        chk("rst_ack",    32'(req_ack),   32'h0);
        chk("rst_srdyi",  32'(cs_srdyi),  32'h0);
        chk("rst_err",    32'(err_o),     32'h0);
        rise();
        GlobalReset = 1'b1;

        // First issue uses reset table values
        en = 1'b1;
        req_valid = 4'b0010;
        req_data[21 +: 21] = 21'h1ABCD;
        wait_ack("rst_ack_ch1", 4'b0010);
        req_valid = '0;
        half();
        chk("rst_issue_srdyi", 32'(cs_srdyi), 32'h1);
        chk("rst_issue_mean",  cs_mean,       32'h0000_0000);
        chk("rst_issue_std",   cs_std,        32'h3F80_0000);
        rise();

        // Config table write then issue from channel 2
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_sel = 1'b0; cfg_data = 32'h4444_4444;
        half(); rise();
        cfg_sel = 1'b1; cfg_data = 32'h4000_0000;
        half(); rise();
        cfg_we = 1'b0;
        req_valid = 4'b0100;
        req_data[42 +: 21] = 21'h088888;
        wait_ack("cfg_ack", 4'b0100);
        req_valid = '0;
        half();
        chk("cfg_srdyi", 32'(cs_srdyi), 32'h1);
        chk("cfg_x",     32'(cs_x_adc), 32'h0008_8888);
        chk("cfg_mean",  cs_mean,       32'h4444_4444);
        chk("cfg_std",   cs_std,        32'h4000_0000);
        rise();
        cycles(12);

        // Round robin from a fresh pointer
        GlobalReset = 1'b0;
        cycles(2);
        GlobalReset = 1'b1;
        grant_log.delete();
        zch_log.delete();
        lat = 3;
        req_valid = 4'b1111;
        begin
            int i;
            i = 0;
            half();
            while (grant_log.size() < 5 && i < 50) begin
                rise();
                half();
                i++;
            end
            rise();
            req_valid = '0;
            i = 0;
            while (zch_log.size() < 5 && i < 50) begin
                half();
                rise();
                i++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            chk("rr_grant", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(rr_exp[i]));
            chk("rr_zch",   (i < zch_log.size())   ? 32'(zch_log[i])   : 32'hFFFF_FFFF, 32'(rr_exp[i]));
        end
        cycles(10);

        // Full: centerScale withholds results
        cs_hold = 1'b1;
        srdyi_cnt = 0;
        req_valid = 4'b0001;
        cycles(20);
        half();
        chk("full_issues", 32'(srdyi_cnt), 32'd4);
        chk("full_ack",    32'(req_ack),   32'h0);
        rise();
        rel_req = 1;
        cycles(10);
        half();
        chk("full_one_more", 32'(srdyi_cnt), 32'd5);
        chk("full_ack2",     32'(req_ack),   32'h0);
        rise();
        req_valid = '0;
        cs_hold = 1'b0;
        cycles(15);

        // Drain with three samples in flight
        cs_hold = 1'b1;
        ack_cnt = 0;
        req_valid = 4'b0111;
        begin
            int i;
            i = 0;
            half();
            while (ack_cnt < 3 && i < 30) begin
                rise();
                half();
                i++;
            end
            rise();
            req_valid = '0;
            en = 1'b0;
            cycles(6);
            half();
            chk("drain_busy", 32'(busy_o),  32'h1);
            chk("drain_acks", 32'(ack_cnt), 32'd3);
            rise();
            cs_hold = 1'b0;
            zv_cnt = 0;
            i = 0;
            while (zv_cnt < 3 && i < 30) begin
                half();
                rise();
                i++;
            end
            chk("drain_results", 32'(zv_cnt), 32'd3);
            cycles(1);
            half();
            chk("drain_idle", 32'(busy_o), 32'h0);
            rise();
        end

        // Randomized traffic with config writes and a mid-run reset
        GlobalReset = 1'b0;
        cycles(1);
        GlobalReset = 1'b1;
        last_ack = '0;
        for (int n = 0; n < 800; n++) begin
            en = ($urandom_range(0, 9) != 0);
            for (int ch = 0; ch < NCH; ch++) begin
                if (last_ack[ch]) begin
                    req_valid[ch] = 1'($urandom_range(0, 1));
                    req_data[ch*21 +: 21] = 21'($urandom);
                end else if (!req_valid[ch] && $urandom_range(0, 2) == 0) begin
                    req_valid[ch] = 1'b1;
                    req_data[ch*21 +: 21] = 21'($urandom);
                end
            end
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_ch   = 2'($urandom);
            cfg_sel  = 1'($urandom);
            cfg_data = $urandom;
            lat      = $urandom_range(1, 6);
            if (n == 400) GlobalReset = 1'b0;
            if (n == 402) GlobalReset = 1'b1;
            half();
            last_ack = req_ack;
            rise();
        end

        // Spurious return with nothing in flight
        en = 1'b0; req_valid = '0; cfg_we = 1'b0;
        cycles(30);
        GlobalReset = 1'b0;
        cycles(1);
        GlobalReset = 1'b1;
        half();
        chk("err_clear", 32'(err_o), 32'h0);
        rise();
        zv_cnt = 0;
        spur_req = 1;
        cycles(2);
        half();
        chk("err_set", 32'(err_o), 32'h1);
        rise();
        cycles(5);
        half();
        chk("err_sticky", 32'(err_o),  32'h1);
        chk("err_no_z",   32'(zv_cnt), 32'd0);
        rise();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
